// File: rtl/ser_link_pkg.sv
// Shared definitions for the serial-link arbiter: FSM state encoding,
// default word geometry and a constant-function clog2 helper.
package ser_link_pkg;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_PRE_ENC   = 2'd1;
  localparam logic [1:0] ST_SHIFT_ENC = 2'd2;
  localparam logic [1:0] ST_GAP_ENC   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_PRE   = ST_PRE_ENC,
    ST_SHIFT = ST_SHIFT_ENC,
    ST_GAP   = ST_GAP_ENC
  } state_e;

  localparam int         DEF_WORD_W    = 32;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'h5A;

  // Number of bits needed to index 'value' items (value >= 2).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/ser_link_arbiter_rr_arbiter.sv
// Combinational rotating-priority picker. Searches last_i+1 .. last_i
// (wrapping) and returns the first active request as one-hot and index.
// Shared with the receive-side scheduler.
module rr_arbiter
  import ser_link_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk the rotated priority order and keep the first hit.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // signal unassigned; an unassigned path would infer a latch.
    gnt_o    = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand     = (int'(last_i) + off) % NUM_REQ;
      cand_idx = cand[IDX_W-1:0];
      if (!valid_o && req_i[cand_idx]) begin
        valid_o         = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/ser_link_arbiter.sv
// Round-robin arbiter/sequencer sharing one parallel-to-serial converter
// among NUM_REQ word sources. Grants a source, loads its word with a
// one-cycle start strobe, owns the converter for WORD_W bit-times, then
// idles GAP_CYCLES before re-arbitrating.
// Optional build macro SER_LINK_SYNC_PREAMBLE_EN: each word is preceded by
// a full-width preamble word built from SYNC_BYTE (extra PRE state).
module ser_link_arbiter
  import ser_link_pkg::*;
#(
  parameter  int         NUM_REQ    = 4,
  parameter  int         WORD_W     = DEF_WORD_W,
  parameter  int         GAP_CYCLES = 1,
  parameter  logic [7:0] SYNC_BYTE  = DEF_SYNC_BYTE,
  localparam int         IDX_W      = clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*WORD_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [IDX_W-1:0]          grant_id_o,
  output logic                      ser_start_o,
  output logic [WORD_W-1:0]         ser_p_in_o,
  output logic                      busy_o
);

  localparam int               CNT_W     = clog2(WORD_W);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_DONE  = CNT_W'(WORD_W - 2);
  localparam logic [3:0]       GAP_LAST  = 4'(GAP_CYCLES - 1);
  localparam bit               NO_GAP    = (GAP_CYCLES == 0);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [3:0]          gap_q;
  logic [IDX_W-1:0]    last_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [NUM_REQ-1:0]  done_q;
  logic [IDX_W-1:0]    grant_id_q;
  logic                ser_start_q;
  logic [WORD_W-1:0]   ser_p_in_q;
`ifdef SER_LINK_SYNC_PREAMBLE_EN
  localparam logic [WORD_W-1:0] PREAMBLE = {(WORD_W / 8){SYNC_BYTE}};
  logic [WORD_W-1:0]   data_q;
`endif

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_valid;
  logic                arb_now_d;
  logic [WORD_W-1:0]   word_d;
  logic [NUM_REQ-1:0]  owner_oh_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i   (req_i),
    .last_i  (last_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Arbitration slot: idle, or the final cycle before the converter frees up.
  always_comb begin
    arb_now_d = (state_q == ST_IDLE)
             || (NO_GAP  && state_q == ST_SHIFT && cnt_q == CNT_LAST)
             || (!NO_GAP && state_q == ST_GAP   && gap_q == GAP_LAST);
  end

  // Winner's word and the current owner's one-hot, via constant selects.
  always_comb begin
    word_d     = '0;
    owner_oh_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) word_d = req_data_i[i*WORD_W +: WORD_W];
      owner_oh_d[i] = (grant_id_q == IDX_W'(i));
    end
  end

  // Sequencer FSM with registered strobes; a grant overrides the state step.
  always_ff @(posedge clk_i) begin
    // NOTE: state is written only with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (reset_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      gap_q       <= '0;
      last_q      <= LAST_INIT;
      gnt_q       <= '0;
      done_q      <= '0;
      grant_id_q  <= '0;
      ser_start_q <= 1'b0;
      ser_p_in_q  <= '0;
`ifdef SER_LINK_SYNC_PREAMBLE_EN
      data_q      <= '0;
`endif
    end else begin
      gnt_q       <= '0;
      done_q      <= '0;
      ser_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: ;
`ifdef SER_LINK_SYNC_PREAMBLE_EN
        ST_PRE: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_q       <= '0;
            ser_p_in_q  <= data_q;
            ser_start_q <= 1'b1;
            state_q     <= ST_SHIFT;
          end
        end
`endif
        ST_SHIFT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_DONE) done_q <= owner_oh_d;
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            gap_q   <= '0;
            state_q <= NO_GAP ? ST_IDLE : ST_GAP;
          end
        end
        ST_GAP: begin
          gap_q <= gap_q + 1'b1;
          if (gap_q == GAP_LAST) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      if (arb_now_d && arb_valid) begin
        gnt_q       <= arb_gnt;
        ser_start_q <= 1'b1;
        grant_id_q  <= arb_idx;
        last_q      <= arb_idx;
        cnt_q       <= '0;
`ifdef SER_LINK_SYNC_PREAMBLE_EN
        ser_p_in_q  <= PREAMBLE;
        data_q      <= word_d;
        state_q     <= ST_PRE;
`else
        ser_p_in_q  <= word_d;
        state_q     <= ST_SHIFT;
`endif
      end
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign grant_id_o  = grant_id_q;
  assign ser_start_o = ser_start_q;
  assign ser_p_in_o  = ser_p_in_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ser_link_arbiter.sv
// Directed bench for ser_link_arbiter. Instance 'dut' uses GAP_CYCLES=1,
// instance 'dut0' uses GAP_CYCLES=0; both share clock and inputs.
// Inputs are driven and outputs sampled on the falling edge. Sample index n
// counts falling edges after the grant (n=0 is the grant cycle).
module tb_ser_link_arbiter;

  localparam int NR = 4;
  localparam int WW = 32;
`ifdef SER_LINK_SYNC_PREAMBLE_EN
  localparam int PRE_LEN = WW;
`else
  localparam int PRE_LEN = 0;
`endif
  localparam int          WLEN      = PRE_LEN + WW;
  localparam logic [31:0] SYNC_WORD = 32'h5A5A5A5A;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req;
  logic [NR*WW-1:0] req_data;

  logic [NR-1:0] gnt, done, gnt0, done0;
  logic [1:0]    gid, gid0;
  logic          sstart, sstart0, busy, busy0;
  logic [WW-1:0] sp, sp0;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ser_link_arbiter #(.NUM_REQ(NR), .WORD_W(WW), .GAP_CYCLES(1)) dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .req_data_i(req_data),
    .gnt_o(gnt), .done_o(done), .grant_id_o(gid), .ser_start_o(sstart),
    .ser_p_in_o(sp), .busy_o(busy)
  );

  ser_link_arbiter #(.NUM_REQ(NR), .WORD_W(WW), .GAP_CYCLES(0)) dut0 (
    .clk_i(clk), .reset_i(reset), .req_i(req), .req_data_i(req_data),
    .gnt_o(gnt0), .done_o(done0), .grant_id_o(gid0), .ser_start_o(sstart0),
    .ser_p_in_o(sp0), .busy_o(busy0)
  );

  task automatic apply_reset();
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    req      = '0;
    req_data = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({gnt, done, gid, sstart, busy} !== '0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got gnt=%b done=%b gid=%0d start=%b busy=%b, want all 0",
               gnt, done, gid, sstart, busy);
    end
    tests_run++;
    if (sp !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got ser_p_in=%h, want 0", sp);
    end
    tests_run++;
    if ({gnt0, done0, gid0, sstart0, busy0, sp0} !== '0) begin
      tests_failed++;
      $display("FAIL reset_dut0: got gnt=%b done=%b start=%b busy=%b p=%h, want all 0",
               gnt0, done0, sstart0, busy0, sp0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({gnt, sstart, busy} !== '0) begin
      tests_failed++;
      $display("FAIL idle_no_req: got gnt=%b start=%b busy=%b, want 0", gnt, sstart, busy);
    end
  endtask

  // One word from a lone source on 'dut' (GAP_CYCLES=1).
  task automatic test_word(input int src, input logic [31:0] word, input string name);
    logic [NR-1:0] oh, exp_gnt, exp_done;
    logic          exp_start, exp_busy;
    logic [31:0]   exp_p;
    oh = '0;
    oh[src] = 1'b1;
    apply_reset();
    req[src] = 1'b1;
    req_data[src*WW +: WW] = word;
    for (int n = 0; n <= WLEN + 1; n++) begin
      @(negedge clk);
      exp_gnt   = (n == 0) ? oh : '0;
      exp_done  = (n == WLEN - 1) ? oh : '0;
      exp_start = (n == 0) || (PRE_LEN > 0 && n == PRE_LEN);
      exp_busy  = (n <= WLEN);
      tests_run++;
      if ({gnt, done, sstart, busy} !== {exp_gnt, exp_done, exp_start, exp_busy}) begin
        tests_failed++;
        $display("FAIL %s_ctrl n=%0d: got gnt=%b done=%b start=%b busy=%b, want %b %b %b %b",
                 name, n, gnt, done, sstart, busy, exp_gnt, exp_done, exp_start, exp_busy);
      end
      if (n < WLEN) begin
        exp_p = (n < PRE_LEN) ? SYNC_WORD : word;
        tests_run++;
        if (sp !== exp_p) begin
          tests_failed++;
          $display("FAIL %s_data n=%0d: got ser_p_in=%h, want %h", name, n, sp, exp_p);
        end
      end
      if (n == 0) begin
        tests_run++;
        if (gid !== 2'(src)) begin
          tests_failed++;
          $display("FAIL %s_gid: got %0d, want %0d", name, gid, src);
        end
        // Source lets go after its grant and scribbles its data; must be ignored.
        req[src] = 1'b0;
        req_data[src*WW +: WW] = ~word;
      end
    end
  endtask

  task automatic test_single();
    test_word(0, 32'h0000FFFF, "single");
  endtask

  task automatic test_preamble();
    test_word(2, 32'hA5A5A5A5, "preamble");
  endtask

  // Sources 1 and 2 request together on 'dut'; 1 wins, 2 follows WLEN+1 later.
  task automatic test_contention();
    logic [NR-1:0] exp_gnt, exp_done;
    logic [31:0]   exp_p;
    apply_reset();
    req = 4'b0110;
    req_data[1*WW +: WW] = 32'h11111111;
    req_data[2*WW +: WW] = 32'h22222222;
    for (int n = 0; n <= 2 * WLEN + 2; n++) begin
      @(negedge clk);
      exp_gnt  = (n == 0) ? 4'b0010 : (n == WLEN + 1) ? 4'b0100 : 4'b0000;
      exp_done = (n == WLEN - 1) ? 4'b0010 : (n == 2 * WLEN) ? 4'b0100 : 4'b0000;
      tests_run++;
      if ({gnt, done} !== {exp_gnt, exp_done}) begin
        tests_failed++;
        $display("FAIL contention n=%0d: got gnt=%b done=%b, want %b %b",
                 n, gnt, done, exp_gnt, exp_done);
      end
      if (n == 0) begin
        tests_run++;
        if (gid !== 2'd1) begin
          tests_failed++;
          $display("FAIL contention_gid1: got %0d, want 1", gid);
        end
        req[1] = 1'b0;
      end
      if (n == WLEN + 1) begin
        exp_p = (PRE_LEN > 0) ? SYNC_WORD : 32'h22222222;
        tests_run++;
        if (gid !== 2'd2 || sp !== exp_p) begin
          tests_failed++;
          $display("FAIL contention_second: got gid=%0d p=%h, want 2 %h", gid, sp, exp_p);
        end
        req[2] = 1'b0;
      end
      if (n == 2 * WLEN + 2) begin
        tests_run++;
        if (busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL contention_idle: got busy=%b, want 0", busy);
        end
      end
    end
  endtask

  // All four held on 'dut0' (GAP_CYCLES=0): grants 0,1,2,3,0 back to back.
  task automatic test_fairness();
    logic [NR-1:0] exp_gnt, exp_done;
    logic          exp_start;
    int            pos, owner;
    apply_reset();
    for (int i = 0; i < NR; i++) req_data[i*WW +: WW] = 32'(i + 1) * 32'h01010101;
    req = 4'b1111;
    for (int n = 0; n <= 4 * WLEN; n++) begin
      @(negedge clk);
      pos       = n % WLEN;
      owner     = (n / WLEN) % NR;
      exp_gnt   = (pos == 0) ? 4'(1 << owner) : '0;
      exp_done  = (pos == WLEN - 1) ? 4'(1 << owner) : '0;
      exp_start = (pos == 0) || (PRE_LEN > 0 && pos == PRE_LEN);
      tests_run++;
      if ({gnt0, done0, sstart0, busy0} !== {exp_gnt, exp_done, exp_start, 1'b1}) begin
        tests_failed++;
        $display("FAIL fairness n=%0d: got gnt=%b done=%b start=%b busy=%b, want %b %b %b 1",
                 n, gnt0, done0, sstart0, busy0, exp_gnt, exp_done, exp_start);
      end
      if (pos == 0) begin
        tests_run++;
        if (gid0 !== 2'(owner)) begin
          tests_failed++;
          $display("FAIL fairness_gid n=%0d: got %0d, want %0d", n, gid0, owner);
        end
      end
      if (pos == PRE_LEN) begin
        tests_run++;
        if (sp0 !== 32'(owner + 1) * 32'h01010101) begin
          tests_failed++;
          $display("FAIL fairness_data n=%0d: got %h, want %h",
                   n, sp0, 32'(owner + 1) * 32'h01010101);
        end
      end
    end
    req = '0;
  endtask

  // REQ[3] pulses for one cycle mid-word on 'dut'; it must never be granted.
  task automatic test_withdrawn();
    apply_reset();
    req = 4'b0001;
    req_data[0 +: WW] = 32'h12345678;
    for (int n = 0; n <= WLEN + 3; n++) begin
      @(negedge clk);
      tests_run++;
      if (gnt !== ((n == 0) ? 4'b0001 : 4'b0000)) begin
        tests_failed++;
        $display("FAIL withdrawn_gnt n=%0d: got %b, want %b",
                 n, gnt, (n == 0) ? 4'b0001 : 4'b0000);
      end
      if (n > WLEN) begin
        tests_run++;
        if (busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL withdrawn_busy n=%0d: got %b, want 0", n, busy);
        end
      end
      if (n == 0) req[0] = 1'b0;
      if (n == 5) req[3] = 1'b1;
      if (n == 6) req[3] = 1'b0;
    end
  endtask

  // Reset at bit 10 of a word aborts it; afterwards 0 beats 3 (last_grant=3).
  task automatic test_reset_mid();
    logic [NR-1:0] exp_gnt, exp_done;
    apply_reset();
    req = 4'b0001;
    req_data[0 +: WW] = 32'hC0DE0001;
    for (int n = 0; n <= 10; n++) begin
      @(negedge clk);
      if (n == 0) begin
        tests_run++;
        if (gnt !== 4'b0001) begin
          tests_failed++;
          $display("FAIL resetmid_first_gnt: got %b, want 0001", gnt);
        end
        req[0] = 1'b0;
      end
    end
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({gnt, done, gid, sstart, busy, sp} !== '0) begin
      tests_failed++;
      $display("FAIL resetmid_clear: got gnt=%b done=%b gid=%0d start=%b busy=%b p=%h, want 0",
               gnt, done, gid, sstart, busy, sp);
    end
    reset = 1'b0;
    req   = 4'b1001;
    req_data[0 +: WW]    = 32'hC0DE0002;
    req_data[3*WW +: WW] = 32'hC0DE0003;
    for (int m = 0; m <= WLEN + 2; m++) begin
      @(negedge clk);
      exp_gnt  = (m == 0) ? 4'b0001 : (m == WLEN + 1) ? 4'b1000 : 4'b0000;
      exp_done = (m == WLEN - 1) ? 4'b0001 : 4'b0000;
      tests_run++;
      if ({gnt, done} !== {exp_gnt, exp_done}) begin
        tests_failed++;
        $display("FAIL resetmid m=%0d: got gnt=%b done=%b, want %b %b",
                 m, gnt, done, exp_gnt, exp_done);
      end
      if (m == 0) req[0] = 1'b0;
      if (m == WLEN + 1) begin
        tests_run++;
        if (gid !== 2'd3) begin
          tests_failed++;
          $display("FAIL resetmid_gid: got %0d, want 3", gid);
        end
        req = '0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_withdrawn();
    test_reset_mid();
    test_preamble();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ser_link_arbiter.md
Name: ser_link_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one parallel-to-serial converter among NUM_REQ word sources.
- Picks a requester, latches its word onto SER_P_IN and pulses SER_START.
- Holds the converter for WORD_W bit-times, then signals completion and re-arbitrates.
- Sits between the link clients and the serializer. The serializer shifts one bit per CLK, MSB first, after SER_START.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WORD_W, 32, serializer word width and bit-times per word
GAP_CYCLES, 1, idle CLK cycles between words (0..15)
SYNC_BYTE, 8'h5A, byte replicated into the preamble word (used only with the optional feature)

Ports:
CLK  in  1  single clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
REQ  in  NUM_REQ  level request per source
REQ_DATA  in  NUM_REQ*WORD_W  word per source, source i at [i*WORD_W +: WORD_W]
GNT  out  NUM_REQ  one-hot, 1-cycle pulse when the word is accepted
DONE  out  NUM_REQ  one-hot, 1-cycle pulse on the last bit-time of the word
GRANT_ID  out  $clog2(NUM_REQ)  index of the current or last owner
SER_START  out  1  1-cycle load strobe to the serializer
SER_P_IN  out  WORD_W  word presented to the serializer
BUSY  out  1  high while not in IDLE

Behaviour:
- Reset (synchronous, RESET=1 at an edge): all outputs 0, state IDLE, bit counter 0, last_grant=NUM_REQ-1 so requester 0 has priority first. Reset mid-word aborts the word: no DONE is issued.
- States: IDLE, SHIFT, GAP.
- Arbitration: priority order last_grant+1 .. last_grant, wrapping modulo NUM_REQ.
- IDLE: at an edge where REQ!=0, select winner i. For the following cycle:
  - GNT[i]=1, SER_START=1, SER_P_IN=REQ_DATA[i], GRANT_ID=i, last_grant=i, counter=0.
  - State moves to SHIFT.
- SHIFT: counter increments each cycle. SER_P_IN is held stable for the whole word. SER_START is high only in the first cycle.
  - In the cycle where counter==WORD_W-1, DONE[i]=1.
  - Next state is GAP, or IDLE if GAP_CYCLES=0.
- GAP: counts GAP_CYCLES cycles, then goes to IDLE.
- Latency: REQ sampled at edge k gives GNT/SER_START in cycle k+1 and DONE in cycle k+WORD_W. With GAP_CYCLES=0, the next GNT can occur in cycle k+WORD_W+1 (back-to-back, no idle bit).
- Request rules:
  - A requester holds REQ and REQ_DATA until GNT.
  - REQ dropped before being sampled in IDLE: no grant, nothing sent.
  - REQ still high after GNT is treated as a new request.
  - REQ/REQ_DATA changes during SHIFT/GAP are ignored.
- Simultaneous REQ: exactly one winner per grant; the others stay pending.
- BUSY = state!=IDLE. GNT, DONE and SER_START are never high outside the cycles stated above.

Optional Feature:
- Macro: SER_LINK_SYNC_PREAMBLE_EN.
- Defined: adds state PRE between IDLE and SHIFT.
  - On the grant cycle, SER_P_IN={WORD_W/8{SYNC_BYTE}} (0x5A5A5A5A) with SER_START=1. GNT fires in this cycle.
  - After WORD_W cycles, SER_P_IN=REQ_DATA latched at grant, with a second SER_START pulse, then SHIFT as above.
  - DONE moves to grant cycle + 2*WORD_W - 1.
- Undefined: no PRE state and no preamble; timing exactly as in Behaviour.

Decomposition:
- Package ser_link_pkg holds:
  - state encoding localparams (IDLE, PRE, SHIFT, GAP);
  - default WORD_W and SYNC_BYTE;
  - a clog2 helper function.
- Sub-module rr_arbiter: combinational rotating-priority picker.
  - Inputs: REQ, last_grant.
  - Outputs: one-hot grant and index.
  - Reusable by the receive-side scheduler.

Test Plan:
- Single source: REQ[0]=1, data 0x0000FFFF → GNT[0] and SER_START in cycle k+1, SER_P_IN=0x0000FFFF for 32 cycles, DONE[0] in cycle k+32, BUSY=0 after GAP.
- Contention: REQ=4'b0110 simultaneous → grant order 1 then 2, second GNT exactly 32+GAP_CYCLES cycles after the first.
- Fairness: REQ=4'b1111 held, GAP_CYCLES=0 → grants 0,1,2,3,0 with no idle cycles between words and SER_START period of 32.
- Withdrawn request: REQ[3] pulsed for one cycle during SHIFT of source 0 → source 3 is never granted.
- Reset mid-word: RESET=1 at bit 10 of a word → next cycle all outputs 0 with no DONE. After release, REQ=4'b1001 grants source 0 first.
- Preamble (macro defined): REQ[2] data 0xA5A5A5A5 → SER_P_IN=0x5A5A5A5A for 32 cycles, then 0xA5A5A5A5. Two SER_START pulses 32 cycles apart, DONE[2] at grant+63.
